// File: rtl/hazard_stall_unit_pkg.sv
// Shared core definitions: hazard FSM states and the x0 register constant.
// Reused by the forwarding and decode logic as well as the stall unit.
package hazard_stall_unit_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when an operand is actually read and names the given register.
   function automatic logic reg_match(logic [4:0] rs, logic use_rs, logic [4:0] rd);
      return use_rs && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: advances by one per inc cycle and sticks at all-ones.
module sat_counter
   import hazard_stall_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection / stall controller: load-use stalls, branch flushes,
// memory-wait freeze with a watchdog that halts the core on timeout.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32,
   parameter int WAIT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rd,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic [CNT_W-1:0] wait_cycles
);

   hz_state_e         state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              timeout_nxt;
   logic              mwait, lu;
   logic              win_wait, win_flush, win_stall;

   assign mwait = dmem_req && !dmem_ready;
   assign lu    = id_ex_memread && (id_ex_rd != REG_ZERO) &&
                  (reg_match(id_rs1, id_use_rs1, id_ex_rd) ||
                   reg_match(id_rs2, id_use_rs2, id_ex_rd));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = mem_timeout;
      case (state)
         RUN: begin
            if (mwait) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!mwait) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
               state_nxt   = HALT;
               timeout_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   // Reset presents the idle decode so a pending memory wait cannot keep
   // the pipeline frozen while reset is held.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      win_wait     = 1'b0;
      win_flush    = 1'b0;
      win_stall    = 1'b0;
      if (reset) begin
         pc_write = 1'b1;
      end else if (state == HALT) begin
         pipe_freeze = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (mwait) begin
         pipe_freeze = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         win_wait    = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         win_flush    = 1'b1;
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         win_stall    = 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .inc(win_stall), .count(stall_cycles)
   );
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(win_flush), .count(flush_events)
   );
   sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk(clk), .reset(reset), .inc(win_wait), .count(wait_cycles)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_stall_unit;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int WAIT_W  = 3;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, id_ex_rd;
   logic             id_use_rs1, id_use_rs2, id_ex_memread;
   logic             ex_branch_taken, dmem_req, dmem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic             pipe_freeze, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_events, wait_cycles;

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model: halted flag, length of the current wait run, counts.
   bit m_halt;
   int m_run, m_st, m_fl, m_wt;

   hazard_stall_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_events(flush_events),
      .wait_cycles(wait_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      else
         n_pass++;
   endtask

   function automatic int sat_inc(int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   always @(negedge clk) begin
      bit mw, lu;
      bit e_pc, e_ifid, e_fl, e_bub, e_frz;
      if (reset) begin
         m_halt = 0; m_run = 0; m_st = 0; m_fl = 0; m_wt = 0;
      end
      chk("stall_cycles", 32'(stall_cycles), m_st);
      chk("flush_events", 32'(flush_events), m_fl);
      chk("wait_cycles",  32'(wait_cycles),  m_wt);
      chk("mem_timeout",  32'(mem_timeout),  32'(m_halt));
      mw = dmem_req && !dmem_ready;
      lu = id_ex_memread && id_ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
      e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_frz = 0;
      if (!reset) begin
         if (m_halt || mw) begin
            e_frz = 1; e_pc = 0; e_ifid = 0;
         end else if (ex_branch_taken) begin
            e_fl = 1; e_bub = 1;
         end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
         end
      end
      chk("pc_write",     32'(pc_write),     32'(e_pc));
      chk("if_id_write",  32'(if_id_write),  32'(e_ifid));
      chk("if_id_flush",  32'(if_id_flush),  32'(e_fl));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("pipe_freeze",  32'(pipe_freeze),  32'(e_frz));
      if (!reset && !m_halt) begin
         if (mw) begin
            m_wt = sat_inc(m_wt);
            m_run++;
            if (m_run == TIMEOUT) m_halt = 1;
         end else begin
            m_run = 0;
            if (ex_branch_taken) m_fl = sat_inc(m_fl);
            else if (lu)         m_st = sat_inc(m_st);
         end
      end
   end

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_ex_memread = 0; id_ex_rd = 0; ex_branch_taken = 0;
      dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic cyc();
      @(negedge clk); #1;
   endtask

   task automatic set_lu();
      id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
   endtask

   task automatic do_reset();
      adv(); reset = 1; idle(); cyc();
      adv(); reset = 0; cyc();
   endtask

   initial begin
      reset = 1; idle();
      cyc();
      adv(); reset = 0; cyc();
      chk("rst_pc_write", 32'(pc_write), 1);
      chk("rst_if_id_write", 32'(if_id_write), 1);
      chk("rst_freeze", 32'(pipe_freeze), 0);
      chk("rst_bubble", 32'(id_ex_bubble), 0);
      chk("rst_counters", 32'(stall_cycles) + 32'(flush_events) + 32'(wait_cycles), 0);

      // single load-use stall
      adv(); set_lu(); cyc();
      chk("lu_pc_write", 32'(pc_write), 0);
      chk("lu_if_id_write", 32'(if_id_write), 0);
      chk("lu_bubble", 32'(id_ex_bubble), 1);
      adv(); idle(); cyc();
      chk("lu_stall_cnt", 32'(stall_cycles), 1);

      // rd=x0 and unused operand do not stall
      do_reset();
      adv(); id_ex_memread = 1; id_ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; cyc();
      chk("x0_pc_write", 32'(pc_write), 1);
      adv(); idle(); id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0; cyc();
      chk("unused_bubble", 32'(id_ex_bubble), 0);
      adv(); idle(); cyc();
      chk("nostall_cnt", 32'(stall_cycles), 0);

      // branch wins over load-use
      do_reset();
      adv(); set_lu(); ex_branch_taken = 1; cyc();
      chk("br_flush", 32'(if_id_flush), 1);
      chk("br_bubble", 32'(id_ex_bubble), 1);
      chk("br_pc_write", 32'(pc_write), 1);
      adv(); idle(); cyc();
      chk("br_flush_cnt", 32'(flush_events), 1);
      chk("br_stall_cnt", 32'(stall_cycles), 0);

      // 3-cycle memory wait, branch held off until release
      do_reset();
      for (int i = 0; i < 3; i++) begin
         adv(); dmem_req = 1; dmem_ready = 0; ex_branch_taken = (i == 1); cyc();
         chk("mw_freeze", 32'(pipe_freeze), 1);
         chk("mw_noflush", 32'(if_id_flush), 0);
      end
      adv(); dmem_req = 1; dmem_ready = 1; ex_branch_taken = 1; cyc();
      chk("rel_freeze", 32'(pipe_freeze), 0);
      chk("rel_flush", 32'(if_id_flush), 1);
      adv(); idle(); cyc();
      chk("mw_wait_cnt", 32'(wait_cycles), 3);
      chk("mw_flush_cnt", 32'(flush_events), 1);

      // watchdog timeout, then reset during a pending wait
      do_reset();
      for (int i = 0; i < TIMEOUT; i++) begin
         adv(); dmem_req = 1; dmem_ready = 0; cyc();
         chk("to_freeze", 32'(pipe_freeze), 1);
      end
      adv(); dmem_req = 1; dmem_ready = 1; cyc();
      chk("halt_freeze", 32'(pipe_freeze), 1);
      chk("halt_timeout", 32'(mem_timeout), 1);
      chk("halt_wait_cnt", 32'(wait_cycles), 4);
      adv(); reset = 1; dmem_req = 1; dmem_ready = 0; cyc();
      chk("rst_halt_freeze", 32'(pipe_freeze), 0);
      chk("rst_halt_timeout", 32'(mem_timeout), 0);
      adv(); reset = 0; idle(); cyc();

      // counter saturation
      do_reset();
      for (int i = 0; i < 20; i++) begin
         adv(); set_lu(); cyc();
      end
      adv(); idle(); cyc();
      chk("sat_stall_cnt", 32'(stall_cycles), 15);

      // randomized traffic, alternating light and heavy memory-wait pressure
      for (int seg = 0; seg < 8; seg++) begin
         int preq, prdy;
         preq = (seg % 2) ? 80 : 30;
         prdy = (seg % 2) ? 15 : 60;
         for (int c = 0; c < 200; c++) begin
            adv();
            reset           = ($urandom_range(0, 99) < 2);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            id_use_rs1      = $urandom_range(0, 1) == 1;
            id_use_rs2      = $urandom_range(0, 1) == 1;
            id_ex_memread   = $urandom_range(0, 99) < 50;
            ex_branch_taken = $urandom_range(0, 99) < 15;
            dmem_req        = $urandom_range(0, 99) < preq;
            dmem_ready      = $urandom_range(0, 99) < prdy;
         end
      end
      adv(); reset = 0; idle(); cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
